// File: rtl/dport_pkg.sv
// Shared definitions for the HP0 frame-buffer DMA read path:
// AXI3 encodings, scheduler state encoding and the AXI page size.
package dport_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int PAGE_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arsched_state_e;

endpackage

// File: rtl/dma_arsched_len.sv
// Burst length calculator for the read-address scheduler.
// Works on 8-byte word addresses (byte address bits [31:3]).
// beats = min(BURSTLEN, words left in range, words left in the 4 KB page).
module dma_arsched_len
    import dport_pkg::*;
#(
    parameter int BURSTLEN = 16
)(
    input  logic [31:3] cur_i,
    input  logic [31:3] end_i,
    output logic [4:0]  beats_o,
    output logic [3:0]  arlen_o
);

    logic [28:0] rem_w;
    logic [9:0]  page_w;
    logic [4:0]  beats;

    // Clamp the burst by the configured maximum, the range end and the page end
    always_comb begin
        rem_w  = end_i - cur_i;
        page_w = 10'(PAGE_BYTES / 8) - {1'b0, cur_i[11:3]};
        beats  = 5'(BURSTLEN);
        if (rem_w < 29'(beats)) begin
            beats = rem_w[4:0];
        end
        if (page_w < 10'(beats)) begin
            beats = page_w[4:0];
        end
        beats_o = beats;
        arlen_o = beats[3:0] - 4'd1;
    end

endmodule

// File: rtl/dma_arsched.sv
// Read-address scheduler for the HP0 frame-buffer DMA path (clk = fclk[0]).
// Walks [addrstart, addrend) per frame-start pulse, issuing AXI3 INCR bursts
// under FIFO almost-full back-pressure, an outstanding-burst cap and 4 KB
// page limits. R-channel completions (rlast) retire outstanding bursts.
// Optional build macro: ARSCHED_STATS_EN enables the nbursts/nstall counters;
// without it both outputs are tied to zero.
module dma_arsched
    import dport_pkg::*;
#(
    parameter int          BURSTLEN = 16,
    parameter int          MAXOUT   = 4,
    parameter logic [11:0] ARID     = 12'h000
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] addrstart,
    input  logic [31:0] addrend,
    input  logic        fifoalfull,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [11:0] arid,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] nbursts,
    output logic [15:0] nstall
);

    localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);

    arsched_state_e state_q;
    logic [31:3]    cur_q, endw_q;      // active range, word addresses
    logic [31:3]    ncur_q, nend_q;     // range latched by a mid-frame restart
    logic [31:0]    araddr_q;
    logic [3:0]     arlen_q;
    logic           arvalid_q, busy_q, done_q, err_q;
    logic [3:0]     out_q;

    logic [31:3]    start_w, endin_w, cur_step;
    logic [4:0]     beats;
    logic [3:0]     len_w;
    logic           ar_hs, r_done, uflow, resp_bad, can_issue, range_empty;
    logic           unused_lowbits;

    // Byte-offset bits of the range inputs are ignored; bursts are 8-byte aligned
    assign start_w        = addrstart[31:3];
    assign endin_w        = addrend[31:3];
    assign unused_lowbits = ^{addrstart[2:0], addrend[2:0]};

    assign range_empty = (start_w >= endin_w);
    assign ar_hs       = arvalid_q && arready;
    assign r_done      = rvalid && rlast;
    assign uflow       = r_done && !ar_hs && (out_q == 4'd0);
    assign resp_bad    = rvalid && (rresp != RESP_OKAY);
    // Requiring !arvalid_q also yields the idle cycle after each handshake
    assign can_issue   = !arvalid_q && !fifoalfull && (out_q < MAXOUT_C);
    assign cur_step    = cur_q + 29'(beats);

    dma_arsched_len #(
        .BURSTLEN (BURSTLEN)
    ) u_len (
        .cur_i   (cur_q),
        .end_i   (endw_q),
        .beats_o (beats),
        .arlen_o (len_w)
    );

    // Outstanding-burst count: +1 per AR handshake, -1 per rlast, clamped at 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q <= 4'd0;
        end else begin
            case ({ar_hs, r_done})
                2'b10:   out_q <= out_q + 4'd1;
                2'b01:   if (out_q != 4'd0) out_q <= out_q - 4'd1;
                default: out_q <= out_q;
            endcase
        end
    end

    // Frame sequencing: range latch, burst issue/hold, done/err and restarts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            endw_q    <= '0;
            ncur_q    <= '0;
            nend_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ar_hs) begin
                arvalid_q <= 1'b0;
            end

            if (start && (state_q != ST_IDLE)) begin
                // Restart: let any in-flight AR finish, issue nothing, drain
                ncur_q  <= start_w;
                nend_q  <= endin_w;
                err_q   <= 1'b0;
                state_q <= ST_DRAIN;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            err_q <= 1'b0;
                            if (range_empty) begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end else begin
                                cur_q   <= start_w;
                                endw_q  <= endin_w;
                                busy_q  <= 1'b1;
                                state_q <= ST_ISSUE;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (ar_hs) begin
                            cur_q <= cur_step;
                            if (cur_step == endw_q) begin
                                state_q <= ST_WAIT;
                            end
                        end else if (can_issue) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= {cur_q, 3'b000};
                            arlen_q   <= len_w;
                        end
                    end
                    ST_WAIT: begin
                        if (out_q == 4'd0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (!arvalid_q && (out_q == 4'd0)) begin
                            if (ncur_q >= nend_q) begin
                                err_q   <= 1'b1;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                cur_q   <= ncur_q;
                                endw_q  <= nend_q;
                                state_q <= ST_ISSUE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // Error sources are sticky and win over the clear from a start
            if (resp_bad || uflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arvalid = arvalid_q;
    assign arsize  = SIZE_8B;
    assign arburst = BURST_INCR;
    assign arid    = ARID;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

`ifdef ARSCHED_STATS_EN
    logic [15:0] nbursts_q, nstall_q;
    logic        stall;

    assign stall = (state_q == ST_ISSUE) && !arvalid_q &&
                   (fifoalfull || (out_q >= MAXOUT_C));

    // Per-frame statistics, cleared by every accepted start, saturating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nbursts_q <= 16'd0;
            nstall_q  <= 16'd0;
        end else if (start) begin
            nbursts_q <= 16'd0;
            nstall_q  <= 16'd0;
        end else begin
            if (ar_hs && (nbursts_q != 16'hFFFF)) nbursts_q <= nbursts_q + 16'd1;
            if (stall && (nstall_q != 16'hFFFF))  nstall_q  <= nstall_q + 16'd1;
        end
    end

    assign nbursts = nbursts_q;
    assign nstall  = nstall_q;
`else
    assign nbursts = 16'd0;
    assign nstall  = 16'd0;
`endif

endmodule

// File: doc/dma_arsched.md
Name: dma_arsched

Overview:
- Read-address scheduler for the HP0 frame-buffer DMA path, in the clk (fclk[0]) domain.
- On each frame-start pulse, walks the byte range [addrstart, addrend) and issues AXI3 INCR read bursts.
- Obeys FIFO almost-full back-pressure, a cap on outstanding bursts and 4 KB boundaries.
- Counts R-channel completions. Does not move or store read data; the data path pushes R beats into the pixel FIFO.

Parameters:
- BURSTLEN, 16, max beats per burst (1..16, AXI3 limit).
- MAXOUT, 4, max outstanding AR bursts (1..15).
- ARID, 0, constant 12-bit ID driven on arid.

Ports:
- clk  in  1  system clock (fclk[0]).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  frame-start pulse, one cycle, already synchronised to clk.
- addrstart  in  32  first byte address; bits [2:0] ignored.
- addrend  in  32  end byte address, exclusive; bits [2:0] ignored.
- fifoalfull  in  1  pixel FIFO almost-full.
- araddr  out  32  burst address.
- arlen  out  4  beats-1.
- arsize  out  3  constant 3 (8 bytes).
- arburst  out  2  constant 01 (INCR).
- arid  out  12  ARID.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rvalid  in  1  R valid.
- rlast  in  1  R last.
- rresp  in  2  R response.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last burst of a frame completes.
- err  out  1  sticky error flag.
- nbursts  out  16  statistics (see Optional Feature).
- nstall  out  16  statistics (see Optional Feature).

Behaviour:
- Reset values: arvalid=0, araddr=0, arlen=0, busy=0, done=0, err=0, outstanding count=0, state IDLE. arsize, arburst and arid are constant.
- States:
  - IDLE: no frame active.
  - ISSUE: bursts remain to be issued.
  - WAIT: all bursts issued, outstanding count > 0.
  - DRAIN: restart requested, waiting for outstanding count to reach 0.
- IDLE + start:
  - Latch cur = addrstart & ~7 and end = addrend & ~7.
  - If cur >= end: set err, pulse done next cycle, stay IDLE.
  - Otherwise busy=1 and go to ISSUE.
- Burst length, computed combinationally from registered cur/end: beats = min(BURSTLEN, (end-cur)>>3, (4096-cur[11:0])>>3). arlen = beats-1.
- ISSUE issue condition: !arvalid && !fifoalfull && outstanding < MAXOUT. When it holds, assert arvalid with araddr=cur and arlen.
- arvalid, araddr and arlen hold stable until arready. No withdrawal, even if fifoalfull rises.
- AR handshake (arvalid && arready):
  - cur += beats*8 and outstanding += 1.
  - If the new cur == end, go to WAIT.
  - Next arvalid no earlier than the following cycle, giving one idle cycle between bursts.
- Outstanding count:
  - Decrement on rvalid && rlast. The data path always accepts R beats, so rready is not a port here.
  - AR handshake and rlast in the same cycle leave the count unchanged.
  - A decrement at 0 is an underflow: set err, clamp count at 0.
- WAIT: when outstanding reaches 0, pulse done, clear busy, go to IDLE.
- rresp != 0 on any beat sets err. err clears only on the next start that is accepted.
- start while in ISSUE, WAIT or DRAIN:
  - Record restart-pending, latch the new addrstart/addrend, clear err.
  - Finish any AR handshake in progress, issue nothing further, go to DRAIN.
  - When outstanding reaches 0: no done pulse; begin ISSUE on the latched range (same empty-range check as from IDLE).
- Latency: start to first arvalid is 2 cycles when fifoalfull=0.
- The FIFO ALMOST_FULL_OFFSET must cover MAXOUT*BURSTLEN words. This is an integration rule, not checked by the block.

Optional Feature:
- Macro: ARSCHED_STATS_EN.
- Defined:
  - nbursts counts AR handshakes; nstall counts ISSUE cycles blocked by fifoalfull or the MAXOUT cap.
  - Both clear on an accepted start and saturate at 0xFFFF.
- Undefined: nbursts and nstall are driven to 0 and no counter logic is built.

Decomposition:
- Shared package dport_pkg holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_8B=3'b011, RESP_OKAY=2'b00.
  - State encoding for IDLE/ISSUE/WAIT/DRAIN.
  - PAGE_BYTES=4096.
- One natural sub-module, dma_arsched_len: purely combinational beats/arlen computation from cur, end and BURSTLEN, unit-testable alone.

Test Plan:
- Range 0x1000..0x1400, fifoalfull=0, arready=1, each burst returned as 16 R beats: 8 bursts at 0x1000, 0x1080, ..., 0x1380, all arlen=15; done pulses once after the 8th rlast; busy drops.
- Range 0x0FC0..0x1080: bursts 0x0FC0 arlen=7 (stopped at 4 KB boundary), then 0x1000 arlen=15.
- Range 0x2000..0x2028: single burst, arlen=4. Range 0x3000..0x3000: err=1, done pulse, no arvalid.
- arready=0 for 10 cycles with fifoalfull toggling: araddr and arlen stable, arvalid held. With R withheld: never more than MAXOUT=4 outstanding; with ARSCHED_STATS_EN, nstall increments during those cycles.
- rresp=2'b10 on one beat: err=1 until the next start; frame still completes with done.
- start mid-frame with 3 bursts outstanding: no new arvalid until 3 rlast beats arrive, no done, then first arvalid at the new addrstart.
